irq_ctrl: RTL and testbench

- Interrupt controller; the responder side of the CPU control unit's interrupt handshake.
- Collects peripheral interrupt lines, latches rising edges as pending, and applies mask and fixed priority (index 0 highest).
- Raises O_irq_active toward the control unit. On the control unit's I_irq_ack pulse, delivers the granted IRQ number.
- Tracks in-service interrupts for nesting and retires them on end-of-interrupt (I_eoi).

---
 rtl/irq_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_irq_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// Interrupt controller: the responder side of the control unit's interrupt
// handshake. Rising edges on the peripheral lines become pending requests.
// The mask and a fixed priority (index 0 highest) pick the eligible request,
// and nesting is enforced against the in-service set. The granted number is
// held valid for the control unit's two-cycle number fetch.
module irq_ctrl #(
    parameter int                   NUM_IRQ      = 8,
    parameter int                   NUM_WIDTH    = 16,
    parameter logic [NUM_WIDTH-1:0] SPURIOUS_NUM = 16'hFFFF
) (
    input  logic                 I_clk,
    input  logic                 I_reset,
    input  logic [NUM_IRQ-1:0]   I_irq_lines,
    input  logic                 I_mask_we,
    input  logic [NUM_IRQ-1:0]   I_mask_data,
    input  logic                 I_eoi,
    input  logic                 I_irq_ack,
    output logic                 O_irq_active,
    output logic [NUM_WIDTH-1:0] O_irq_number,
    output logic                 O_number_valid,
    output logic [NUM_IRQ-1:0]   O_pending,
    output logic [NUM_IRQ-1:0]   O_in_service
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        DELIVER1 = 2'd2,
        DELIVER2 = 2'd3
    } state_t;

    state_t               state, state_n;
    logic [NUM_IRQ-1:0]   prev_lines;
    logic [NUM_IRQ-1:0]   pending, pending_n;
    logic [NUM_IRQ-1:0]   in_service, in_service_n;
    logic [NUM_IRQ-1:0]   mask;
    logic [NUM_IRQ-1:0]   edges;
    logic [NUM_IRQ-1:0]   cand;
    logic [NUM_IRQ-1:0]   elig_oh;
    logic                 elig_any;
    logic [NUM_IRQ-1:0]   eoi_clr;
    logic [NUM_IRQ-1:0]   grant_oh;
    logic                 grant;
    logic                 active_n;
    logic                 valid_n;
    logic [NUM_WIDTH-1:0] num_n;

    // One-hot of the lowest set bit (highest priority); zero when v is zero.
    function automatic logic [NUM_IRQ-1:0] lowest_onehot(input logic [NUM_IRQ-1:0] v);
        logic [NUM_IRQ-1:0] r;
        logic               found;
        r     = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (v[i] && !found) begin
                r[i]  = 1'b1;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    // Bits strictly below the lowest set bit of v; all ones when v is zero.
    function automatic logic [NUM_IRQ-1:0] below_lowest(input logic [NUM_IRQ-1:0] v);
        logic [NUM_IRQ-1:0] r;
        logic               stop;
        r    = '0;
        stop = 1'b0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (v[i]) stop = 1'b1;
            if (!stop) r[i] = 1'b1;
        end
        return r;
    endfunction

    // Zero-extended index of a one-hot vector.
    function automatic logic [NUM_WIDTH-1:0] onehot_to_num(input logic [NUM_IRQ-1:0] oh);
        logic [NUM_WIDTH-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (oh[i]) n = NUM_WIDTH'(i);
        end
        return n;
    endfunction

    assign edges    = I_irq_lines & ~prev_lines;
    assign cand     = pending & ~mask;
    assign elig_oh  = lowest_onehot(cand & below_lowest(in_service));
    assign elig_any = |elig_oh;
    // EOI always retires the highest-priority (innermost) in-service level.
    assign eoi_clr  = I_eoi ? lowest_onehot(in_service) : '0;
    assign grant_oh = grant ? elig_oh : '0;

    // A new edge wins over the grant clearing the same pending bit.
    assign pending_n    = (pending & ~grant_oh) | edges;
    // The grant bit is always below the retired bit, so the two never collide.
    assign in_service_n = (in_service & ~eoi_clr) | grant_oh;

    assign O_pending    = pending;
    assign O_in_service = in_service;

    // Handshake FSM state register.
    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) state <= IDLE;
        else         state <= state_n;
    end

    // Next state, grant decision and next values of the handshake outputs.
    always_comb begin
        state_n  = state;
        active_n = O_irq_active;
        valid_n  = O_number_valid;
        num_n    = O_irq_number;
        grant    = 1'b0;
        case (state)
            IDLE: begin
                if (elig_any) begin
                    state_n  = REQ;
                    active_n = 1'b1;
                end else if (I_irq_ack) begin
                    num_n   = SPURIOUS_NUM;
                    valid_n = 1'b1;
                    state_n = DELIVER1;
                end
            end
            REQ: begin
                if (I_irq_ack) begin
                    // Eligibility is re-evaluated at ack time; it may have vanished.
                    active_n = 1'b0;
                    valid_n  = 1'b1;
                    state_n  = DELIVER1;
                    if (elig_any) begin
                        grant = 1'b1;
                        num_n = onehot_to_num(elig_oh);
                    end else begin
                        num_n = SPURIOUS_NUM;
                    end
                end else if (!elig_any) begin
                    active_n = 1'b0;
                    state_n  = IDLE;
                end
            end
            DELIVER1: begin
                active_n = 1'b0;
                state_n  = DELIVER2;
            end
            DELIVER2: begin
                active_n = 1'b0;
                valid_n  = 1'b0;
                state_n  = IDLE;
            end
            default: begin
                active_n = 1'b0;
                valid_n  = 1'b0;
                state_n  = IDLE;
            end
        endcase
    end

    // Edge history, pending, in-service and mask registers.
    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            prev_lines <= '0;
            pending    <= '0;
            in_service <= '0;
            mask       <= '1;
        end else begin
            prev_lines <= I_irq_lines;
            pending    <= pending_n;
            in_service <= in_service_n;
            if (I_mask_we) mask <= I_mask_data;
        end
    end

    // Registered handshake outputs toward the control unit.
    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            O_irq_active   <= 1'b0;
            O_number_valid <= 1'b0;
            O_irq_number   <= '0;
        end else begin
            O_irq_active   <= active_n;
            O_number_valid <= valid_n;
            O_irq_number   <= num_n;
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed testbench for irq_ctrl: handshake latency, priority, nesting,
// masking, spurious acks, simultaneous events and asynchronous reset.
module tb_irq_ctrl;

    logic        I_clk;
    logic        I_reset;
    logic [7:0]  I_irq_lines;
    logic        I_mask_we;
    logic [7:0]  I_mask_data;
    logic        I_eoi;
    logic        I_irq_ack;
    logic        O_irq_active;
    logic [15:0] O_irq_number;
    logic        O_number_valid;
    logic [7:0]  O_pending;
    logic [7:0]  O_in_service;

    int n_checks = 0;
    int n_fail   = 0;

    irq_ctrl #(
        .NUM_IRQ      (8),
        .NUM_WIDTH    (16),
        .SPURIOUS_NUM (16'hFFFF)
    ) dut (
        .I_clk          (I_clk),
        .I_reset        (I_reset),
        .I_irq_lines    (I_irq_lines),
        .I_mask_we      (I_mask_we),
        .I_mask_data    (I_mask_data),
        .I_eoi          (I_eoi),
        .I_irq_ack      (I_irq_ack),
        .O_irq_active   (O_irq_active),
        .O_irq_number   (O_irq_number),
        .O_number_valid (O_number_valid),
        .O_pending      (O_pending),
        .O_in_service   (O_in_service)
    );

    initial I_clk = 1'b0;
    always #5 I_clk = ~I_clk;

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick;
        @(posedge I_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        I_reset     = 1'b1;
        I_irq_lines = 8'h00;
        I_mask_we   = 1'b0;
        I_mask_data = 8'h00;
        I_eoi       = 1'b0;
        I_irq_ack   = 1'b0;
        #1;
        chk("rst_active",  O_irq_active,   0);
        chk("rst_valid",   O_number_valid, 0);
        chk("rst_number",  O_irq_number,   0);
        chk("rst_pending", O_pending,      0);
        chk("rst_insvc",   O_in_service,   0);
        tick; tick;
        I_reset = 1'b0;

        // 1: single IRQ 3, latency and two-cycle delivery
        I_mask_we = 1'b1; I_mask_data = 8'h00;
        tick;
        I_mask_we = 1'b0;
        I_irq_lines = 8'h08;
        tick;
        I_irq_lines = 8'h00;
        chk("t1_pending", O_pending, 8'h08);
        chk("t1_active0", O_irq_active, 0);
        tick;
        chk("t1_active1", O_irq_active, 1);
        I_irq_ack = 1'b1;
        tick;
        I_irq_ack = 1'b0;
        chk("t1_number",  O_irq_number,   3);
        chk("t1_valid_a", O_number_valid, 1);
        chk("t1_act_off", O_irq_active,   0);
        chk("t1_pend0",   O_pending,      0);
        chk("t1_insvc",   O_in_service,   8'h08);
        tick;
        chk("t1_valid_b", O_number_valid, 1);
        tick;
        chk("t1_valid_c", O_number_valid, 0);
        chk("t1_hold",    O_irq_number,   3);
        I_eoi = 1'b1;
        tick;
        I_eoi = 1'b0;
        chk("t1_eoi", O_in_service, 0);

        // 2: lines 5 and 2 together; priority and nesting block
        I_irq_lines = 8'h24;
        tick;
        I_irq_lines = 8'h00;
        chk("t2_pending", O_pending, 8'h24);
        tick;
        chk("t2_active", O_irq_active, 1);
        I_irq_ack = 1'b1;
        tick;
        I_irq_ack = 1'b0;
        chk("t2_num2",  O_irq_number, 2);
        chk("t2_insvc", O_in_service, 8'h04);
        chk("t2_pend",  O_pending,    8'h20);
        tick; tick; tick;
        chk("t2_blocked", O_irq_active, 0);
        I_eoi = 1'b1;
        tick;
        I_eoi = 1'b0;
        chk("t2_eoi", O_in_service, 0);
        tick;
        chk("t2_react", O_irq_active, 1);
        I_irq_ack = 1'b1;
        tick;
        I_irq_ack = 1'b0;
        chk("t2_num5",   O_irq_number, 5);
        chk("t2_insvc5", O_in_service, 8'h20);
        chk("t2_pend0",  O_pending,    0);
        tick; tick;
        I_eoi = 1'b1;
        tick;
        I_eoi = 1'b0;
        chk("t2_eoi5", O_in_service, 0);

        // 3: nesting, IRQ 1 preempts in-service IRQ 4
        I_irq_lines = 8'h10;
        tick;
        I_irq_lines = 8'h00;
        tick;
        I_irq_ack = 1'b1;
        tick;
        I_irq_ack = 1'b0;
        chk("t3_num4",   O_irq_number, 4);
        chk("t3_insvc4", O_in_service, 8'h10);
        tick; tick;
        I_irq_lines = 8'h02;
        tick;
        I_irq_lines = 8'h00;
        tick;
        chk("t3_active", O_irq_active, 1);
        I_irq_ack = 1'b1;
        tick;
        I_irq_ack = 1'b0;
        chk("t3_num1",  O_irq_number, 1);
        chk("t3_nest",  O_in_service, 8'h12);
        tick; tick;
        I_eoi = 1'b1;
        tick;
        I_eoi = 1'b0;
        chk("t3_eoi1", O_in_service, 8'h10);
        I_eoi = 1'b1;
        tick;
        I_eoi = 1'b0;
        chk("t3_eoi4", O_in_service, 0);

        // 7: new edge in the same cycle as the ack clearing that bit
        I_irq_lines = 8'h08;
        tick;
        I_irq_lines = 8'h00;
        tick;
        I_irq_ack = 1'b1; I_irq_lines = 8'h08;
        tick;
        I_irq_ack = 1'b0; I_irq_lines = 8'h00;
        chk("t7_num",      O_irq_number, 3);
        chk("t7_edge_win", O_pending,    8'h08);
        chk("t7_insvc",    O_in_service, 8'h08);
        tick; tick;
        chk("t7_self_blk", O_irq_active, 0);
        I_eoi = 1'b1;
        tick;
        I_eoi = 1'b0;
        tick;
        chk("t7_react", O_irq_active, 1);
        I_irq_ack = 1'b1;
        tick;
        I_irq_ack = 1'b0;
        chk("t7_num2",  O_irq_number, 3);
        chk("t7_pend0", O_pending,    0);
        tick; tick;
        I_eoi = 1'b1;
        tick;
        I_eoi = 1'b0;
        chk("t7_clean", O_in_service, 0);

        // 4: masking keeps pending; unmask activates; re-mask withdraws
        I_mask_we = 1'b1; I_mask_data = 8'hFF;
        tick;
        I_mask_we = 1'b0;
        I_irq_lines = 8'h01;
        tick;
        I_irq_lines = 8'h00;
        chk("t4_pending", O_pending, 8'h01);
        tick; tick;
        chk("t4_masked", O_irq_active, 0);
        I_mask_we = 1'b1; I_mask_data = 8'hFE;
        tick;
        I_mask_we = 1'b0;
        chk("t4_unmask_lat", O_irq_active, 0);
        tick;
        chk("t4_unmask_act", O_irq_active, 1);
        I_mask_we = 1'b1; I_mask_data = 8'hFF;
        tick;
        I_mask_we = 1'b0;
        chk("t4_oldmask", O_irq_active, 1);
        tick;
        chk("t4_withdraw", O_irq_active,   0);
        chk("t4_novalid",  O_number_valid, 0);
        chk("t4_keep",     O_pending,      8'h01);

        // 5: spurious ack; second ack during delivery ignored
        I_irq_ack = 1'b1;
        tick;
        I_irq_ack = 1'b0;
        chk("t5_spur",    O_irq_number,   16'hFFFF);
        chk("t5_valid_a", O_number_valid, 1);
        chk("t5_pend",    O_pending,      8'h01);
        chk("t5_insvc",   O_in_service,   0);
        I_irq_ack = 1'b1;
        tick;
        I_irq_ack = 1'b0;
        chk("t5_valid_b", O_number_valid, 1);
        chk("t5_hold",    O_irq_number,   16'hFFFF);
        tick;
        chk("t5_valid_c", O_number_valid, 0);
        chk("t5_active",  O_irq_active,   0);
        tick;
        chk("t5_no_2nd",  O_number_valid, 0);

        // 6: asynchronous reset during delivery, line 6 held high
        I_irq_lines = 8'h40;
        tick;
        chk("t6_pending", O_pending, 8'h41);
        I_irq_ack = 1'b1;
        tick;
        I_irq_ack = 1'b0;
        chk("t6_in_d1", O_number_valid, 1);
        #2;
        I_reset = 1'b1;
        #1;
        chk("t6_rst_valid",  O_number_valid, 0);
        chk("t6_rst_number", O_irq_number,   0);
        chk("t6_rst_active", O_irq_active,   0);
        chk("t6_rst_pend",   O_pending,      0);
        chk("t6_rst_insvc",  O_in_service,   0);
        tick;
        chk("t6_rst_hold", O_pending, 0);
        I_reset = 1'b0;
        tick;
        chk("t6_first_edge", O_pending, 8'h40);
        tick; tick;
        chk("t6_mask_ones", O_irq_active,   0);
        chk("t6_no_deliv",  O_number_valid, 0);
        I_irq_lines = 8'h00;
        tick;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
